syn_branch_predictor: RTL

- Parametrised dynamic branch predictor: direct-mapped branch target buffer (BTB) with per-entry saturating counters.
- Queried combinationally by the IF stage with the current word PC; returns a predicted next PC.
- Trained once per resolved branch/jump from the EX stage.
- Replaces the static "predict not-taken, flush on taken" policy of the current 5-stage pipeline.

---
 rtl/syn_branch_predictor.sv | 88 ++++++++
 1 files changed

// File: rtl/syn_branch_predictor.sv
// syn_branch_predictor: direct-mapped BTB with saturating counters; optional stats via BP_STATS_EN
module syn_branch_predictor #(
  parameter int ADDR_BIT = 10,
  parameter int IDX_BIT  = 6,
  parameter int CTR_BIT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                flush,
  input  logic [ADDR_BIT-1:0] pc,
  input  logic [ADDR_BIT-1:0] pc_4,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [ADDR_BIT-1:0] pred_pc,
  input  logic                upd_valid,
  input  logic [ADDR_BIT-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [ADDR_BIT-1:0] upd_target,
`ifdef BP_STATS_EN
  input  logic                upd_pred_taken,
  output logic [31:0]         stat_upd,
  output logic [31:0]         stat_mispred,
`endif
  input  logic                upd_is_jump
);
  localparam int N  = 1 << IDX_BIT;
  localparam int TW = ADDR_BIT - IDX_BIT;
  localparam logic [CTR_BIT-1:0] CMAX = '1;
  localparam logic [CTR_BIT-1:0] CWT  = CTR_BIT'(1 << (CTR_BIT - 1));
  logic [N-1:0]          valid_q;
  logic [TW-1:0]         tag_q [N];
  logic [ADDR_BIT-1:0]   tgt_q [N];
  logic [CTR_BIT-1:0]    ctr_q [N];
  logic                  jmp_q [N];
  logic [IDX_BIT-1:0]    idx, uidx;
  logic [TW-1:0]         utag;
  logic                  u_hit, wr_d, jmp_d;
  logic [CTR_BIT-1:0]    cur, ctr_d;
  logic [ADDR_BIT-1:0]   tgt_d;
  logic                  accept;
  assign idx        = pc[IDX_BIT-1:0];
  assign uidx       = upd_pc[IDX_BIT-1:0];
  assign utag       = upd_pc[ADDR_BIT-1:IDX_BIT];
  assign pred_hit   = valid_q[idx] && (tag_q[idx] == pc[ADDR_BIT-1:IDX_BIT]);
  assign pred_taken = pred_hit && ctr_q[idx][CTR_BIT-1];
  assign pred_pc    = pred_taken ? tgt_q[idx] : pc_4;
  assign accept     = en && upd_valid && !flush;
  // next contents of the entry addressed by upd_pc; misses that are not taken leave it alone
  always_comb begin
    u_hit = valid_q[uidx] && (tag_q[uidx] == utag);
    cur   = ctr_q[uidx];
    wr_d  = upd_is_jump || u_hit || upd_taken;
    jmp_d = upd_is_jump;
    tgt_d = (upd_is_jump || upd_taken) ? upd_target : tgt_q[uidx];
    ctr_d = upd_is_jump ? CMAX :
            !u_hit      ? CWT  :
            upd_taken   ? ((cur == CMAX) ? cur : cur + 1'b1) :
                          ((cur == '0)   ? cur : cur - 1'b1);
  end
  // table state: reset beats flush, flush beats update; payload fields need no reset
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else if (en && flush) valid_q <= '0;
    else if (accept && wr_d) begin
      valid_q[uidx] <= 1'b1;
      tag_q[uidx]   <= utag;
      tgt_q[uidx]   <= tgt_d;
      ctr_q[uidx]   <= ctr_d;
      jmp_q[uidx]   <= jmp_d;
    end
  end
`ifdef BP_STATS_EN
  logic [31:0] stat_upd_q, stat_mis_q;
  assign stat_upd     = stat_upd_q;
  assign stat_mispred = stat_mis_q;
  // saturating event counters; a flush does not clear them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else if (accept) begin
      stat_upd_q <= (stat_upd_q == '1) ? stat_upd_q : stat_upd_q + 32'd1;
      if (upd_taken != upd_pred_taken) stat_mis_q <= (stat_mis_q == '1) ? stat_mis_q : stat_mis_q + 32'd1;
    end
  end
`endif
endmodule
